// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One bit per cycle: shift-add multiply (LSB first), restoring divide (MSB first), sign fix-up at the end.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic               neg_res_q, neg_rem_q;
  logic [WIDTH-1:0]   ma_q, mb_q, a_raw_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic               busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] acc_d, product;
  logic [WIDTH-1:0]   rem_d, quot_fix, rem_fix;

  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply: high half accumulates the multiplicand, low half shifts the multiplier out LSB first.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);

  // Divide: the partial remainder is always below the divisor, so WIDTH bits hold it;
  // only the shifted trial value needs the extra bit.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mb_q};
  assign div_ok    = ~div_diff[WIDTH+1];

  assign acc_d = is_div_q ? {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], div_ok}
                          : {mul_sum, acc_q[WIDTH-1:1]};
  assign rem_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

  assign product  = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ma_q      <= '0;
      mb_q      <= '0;
      a_raw_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_div_q  <= op[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            ma_q      <= a_mag;
            mb_q      <= b_mag;
            a_raw_q   <= a;
            acc_q     <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (is_div_q) rem_q <= rem_d;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          if (!is_div_q) begin
            {hi_q, lo_q} <= product;
            dbz_q        <= 1'b0;
          end else if (mb_q == '0) begin
            hi_q  <= a_raw_q;
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end else begin
            hi_q  <= rem_fix;
            lo_q  <= quot_fix;
            dbz_q <= 1'b0;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner-case sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic; SV division truncates toward zero and
  // the remainder takes the dividend's sign, matching the unit's rules.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sr;
    longint unsigned ux, uy, ur;
    logic [63:0]     p;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'h0, x};
    uy = {32'h0, y};
    p  = '0;
    case (o)
      2'b00: begin sr = sx * sy; p = sr; end
      2'b01: begin ur = ux * uy; p = ur; end
      default: begin
        if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
        if (o == 2'b10) p = {32'(sx % sy), 32'(sx / sy)};
        else            p = {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
    return {1'b0, p};
  endfunction

  // Issues one op at the next negedge; returns edges from acceptance to done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    chk("done_low_after_accept", {31'b0, done}, 32'd0);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b lat=%0d", o, x, y, hi, lo, div_by_zero, lat);
  endtask

  task automatic check_result(input string tag, input logic [31:0] eh, input logic [31:0] el,
                              input logic edbz, input int lat);
    chk({tag, "_lat"}, lat, 32'd33);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
    chk({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int          lat;
    int          ndone;
    logic [64:0] m;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [31:0] cap_hi, cap_lo;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
    vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{2'b01, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0};
    vecs[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

    // Reset state with no start
    #12;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Directed table; each op is issued in the previous op's done cycle (back-to-back)
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check_result($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].dbz, lat);
    end

    // start pulsed mid-RUN with a different op must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; cap_hi = '0; cap_lo = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        cap_hi = hi;
        cap_lo = lo;
      end
    end
    $display("[TB] ignored-start sequence: dones=%0d hi=%h lo=%h", ndone, cap_hi, cap_lo);
    chk("midrun_done_count", ndone, 32'd1);
    chk("midrun_hi", cap_hi, 32'd0);
    chk("midrun_lo", cap_lo, 32'd30);

    // Reset asserted at RUN cycle 10 with nonzero HI/LO
    run_op(2'b01, 32'd3, 32'd4, lat);
    check_result("pre_rst", 32'd0, 32'd12, 1'b0, lat);
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    $display("[TB] async reset mid-RUN: busy=%0b hi=%h lo=%h", busy, hi, lo);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 32'd0);
    run_op(2'b11, 32'd100, 32'd7, lat);
    check_result("post_rst", 32'd2, 32'd14, 1'b0, lat);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      m = model(ro, ra, rb);
      run_op(ro, ra, rb, lat);
      check_result($sformatf("rnd%0d", i), m[63:32], m[31:0], m[64], lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
